// File: rtl/seven_seg_if.sv
// Bundle between a display client and the seven_seg scanner.
//   display_0..3 : digit values; bits [3:0] are the hex digit, bits [7:4] are ignored
//   decplace     : index (0..3) of the digit whose decimal point is lit
//   seg          : active-low segments, seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}
//   an           : active-low digit enables, an[k] drives digit k
// There is no handshake. The client drives the values continuously.
// The scanner samples them whenever it updates its outputs.
interface seven_seg_if;
  logic [7:0] display_0;
  logic [7:0] display_1;
  logic [7:0] display_2;
  logic [7:0] display_3;
  logic [1:0] decplace;
  logic [7:0] seg;
  logic [3:0] an;

  modport master (
    output display_0, display_1, display_2, display_3, decplace,
    input  seg, an
  );

  modport slave (
    input  display_0, display_1, display_2, display_3, decplace,
    output seg, an
  );
endinterface

// File: rtl/seven_seg.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Display value 0 is the rightmost digit and display value 3 is the leftmost.
// A free-running counter selects one digit at a time.
// Each digit stays lit for 2**(CTR_WIDTH-2) clocks.
// seg and an are registered. They show the digit decoded from the counter value
// that was present before the edge, so they lag the counter by one cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; blanks the display and clears the counter
//   dsp : seven_seg_if slave (display_0..3 and decplace in; seg and an out)
module seven_seg #(
  parameter int CTR_WIDTH = 18
) (
  input  logic        clk,
  input  logic        rst,
  seven_seg_if.slave  dsp
);

  localparam logic [CTR_WIDTH-1:0] CTR_ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

  logic [CTR_WIDTH-1:0] ctr;
  logic [1:0]           sel;
  logic [3:0]           digit_val;
  logic [7:0]           seg_next;
  logic [3:0]           an_next;
  logic                 unused_hi;

  // The upper nibble of each display value carries no meaning for this block.
  assign unused_hi = ^{dsp.display_0[7:4], dsp.display_1[7:4],
                       dsp.display_2[7:4], dsp.display_3[7:4]};

  assign sel = ctr[CTR_WIDTH-1 -: 2];

  // Active-low hex font. Bit order is {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  always_comb begin
    digit_val = dsp.display_0[3:0];
    case (sel)
      2'd0: digit_val = dsp.display_0[3:0];
      2'd1: digit_val = dsp.display_1[3:0];
      2'd2: digit_val = dsp.display_2[3:0];
      default: digit_val = dsp.display_3[3:0];
    endcase
    seg_next = {(dsp.decplace != sel), hex_font(digit_val)};
    // One-hot-low enable. It is decoded straight from sel, so the pattern
    // stays one-hot when the counter wraps from digit 3 back to digit 0.
    an_next  = ~(4'b0001 << sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr     <= '0;
      dsp.seg <= 8'hFF;
      dsp.an  <= 4'hF;
    end else begin
      ctr     <= ctr + CTR_ONE;
      dsp.seg <= seg_next;
      dsp.an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seven_seg.sv
module tb_seven_seg;

  localparam int CW        = 4;
  localparam int PER_DIGIT = 1 << (CW - 2);

  logic clk;
  logic rst;
  seven_seg_if bus();

  seven_seg #(.CTR_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .dsp (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests;
  int fails;
  bit chk_en;

  // ---------------- behavioural model ----------------
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         edges;   // clock edges since reset release
  logic [7:0] exp_seg = 8'hFF;
  logic [3:0] exp_an  = 4'hF;

  always @(posedge clk or posedge rst) begin
    logic [7:0] dv [4];
    int digit;
    if (rst) begin
      edges   = 0;
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
    end else begin
      dv[0] = bus.display_0; dv[1] = bus.display_1;
      dv[2] = bus.display_2; dv[3] = bus.display_3;
      digit   = (edges / PER_DIGIT) % 4;
      exp_an  = 4'hF ^ (4'(1) << digit);
      exp_seg = {(int'(bus.decplace) != digit), font[dv[digit][3:0]]};
      edges++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_seg", bus.seg, exp_seg);
      check("model_an", {4'h0, bus.an}, {4'h0, exp_an});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [7:0] d0, d1, d2, d3, input logic [1:0] dp);
    bus.display_0 = d0; bus.display_1 = d1;
    bus.display_2 = d2; bus.display_3 = d3;
    bus.decplace  = dp;
  endtask

  // Wait at negedges until an shows the requested pattern, bounded.
  task automatic wait_an(input logic [3:0] v, input string name);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.an === v) begin
        found = 1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL %s: timeout waiting for an=%h, got %h", name, v, bus.an);
    end
  endtask

  // Pulse reset between edges and check that the outputs blank without a clock edge.
  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", bus.seg, 8'hFF);
    check("async_rst_an", {4'h0, bus.an}, 8'h0F);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0; fails = 0; chk_en = 0;
    rst = 1'b1;
    set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 2'd1);

    // 1. reset state, then first edge shows digit 0
    repeat (3) @(negedge clk);
    check("reset_seg", bus.seg, 8'hFF);
    check("reset_an", {4'h0, bus.an}, 8'h0F);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_an", {4'h0, bus.an}, 8'h0E);
    check("first_edge_seg", bus.seg, 8'hC0);
    chk_en = 1;

    // 2. fixed pattern with literal segment codes
    @(negedge clk);
    set_inputs(8'h01, 8'h02, 8'h03, 8'h04, 2'd2);
    wait_an(4'hE, "wait_d0");
    check("pat_d0", bus.seg, 8'hF9);
    wait_an(4'hD, "wait_d1");
    check("pat_d1", bus.seg, 8'hA4);
    wait_an(4'hB, "wait_d2");
    check("pat_d2_dp", bus.seg, 8'h30);
    wait_an(4'h7, "wait_d3");
    check("pat_d3", bus.seg, 8'h99);

    // 3. font sweep on digit 0 with a nonzero upper nibble
    for (int v = 0; v < 16; v++) begin
      wait_an(4'h7, "sweep_sync");
      bus.display_0 = {4'hA, 4'(v)};
      wait_an(4'hE, "sweep_d0");
    end
    bus.display_0 = 8'hF8;
    wait_an(4'hE, "lit8_sync");
    check("lit_font_8", bus.seg, 8'h80);

    // 4. free run across several counter wraps
    repeat (40) @(negedge clk);

    // 5. move the decimal point while digit 1 is shown
    set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 2'd2);
    wait_an(4'hD, "dp_move_sync");
    bus.decplace = 2'd0;
    wait_an(4'hB, "dp_d2");
    check("dp_off_d2", {7'h0, bus.seg[7]}, 8'h01);
    wait_an(4'hE, "dp_d0");
    check("dp_on_d0", bus.seg, 8'h40);

    // 6. reset while digit 2 is lit
    wait_an(4'hB, "rst_sync");
    #2 rst = 1'b1;
    #1;
    check("midscan_rst_seg", bus.seg, 8'hFF);
    check("midscan_rst_an", {4'h0, bus.an}, 8'h0F);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("restart_an", {4'h0, bus.an}, 8'h0E);

    // Randomised run with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   2'($urandom_range(0, 3)));
      if ($urandom_range(0, 99) == 0)
        pulse_rst();
    end

    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
